// File: rtl/fb_fetch_arbiter.sv
// fb_fetch_arbiter: shares one single-port frame RAM between raster-order
// display refill of the pixel FIFO and host pixel writes.
module fb_fetch_arbiter #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LOW_WATER  = 8,
  parameter int unsigned MEM_LAT    = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            frame_start,
  input  logic                            host_req,
  input  logic [ADDR_W-1:0]               host_addr,
  input  logic [DATA_W-1:0]               host_data,
  output logic                            host_gnt,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  input  logic [DATA_W-1:0]               mem_rdata,
  input  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            fifo_wreq,
  output logic [DATA_W-1:0]               fifo_wdata,
  output logic                            busy,
  output logic                            restart_err
);

  localparam int unsigned       CNT_W     = $clog2(FIFO_DEPTH+1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE*V_ACTIVE-1);
  localparam logic [CNT_W:0]    DEPTH_LVL = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W:0]    LOW_LVL   = (CNT_W+1)'(LOW_WATER);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]   pending_q, pending_d;
  logic [MEM_LAT-1:0] vpipe_q, vpipe_d;
  logic [CNT_W:0]     level;
  logic               restart, eligible, urgent, do_read, do_host;

  // Per-cycle arbitration. A restart cycle issues no display read: rd_addr is
  // being rewound, so a read decided now would fetch a stale address.
  always_comb begin
    level    = {1'b0, fifo_count} + {1'b0, pending_q};
    restart  = frame_start && (state_q != IDLE);
    eligible = (state_q == FETCH) && !frame_start && (level < DEPTH_LVL);
    urgent   = eligible && (level < LOW_LVL);
    do_read  = urgent || (eligible && !host_req);
    do_host  = host_req && !urgent;
  end

  // Next state, read pointer, outstanding-read count and valid pipe
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    pending_d = pending_q;
    vpipe_d   = '0;

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d   = FETCH;
          rd_addr_d = '0;
        end
      end
      FETCH: begin
        if (frame_start) begin
          rd_addr_d = '0;
        end else if (do_read) begin
          if (rd_addr_q == LAST_ADDR) state_d = DRAIN;
          else                        rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (frame_start) begin
          state_d   = FETCH;
          rd_addr_d = '0;
        end else if (pending_q == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (restart)                    pending_d = '0;
    else if (do_read && !fifo_wreq) pending_d = pending_q + CNT_W'(1);
    else if (!do_read && fifo_wreq) pending_d = pending_q - CNT_W'(1);

    // Stage 0 loads when the read is on the RAM bus; the last stage lines up
    // with mem_rdata and is the FIFO push itself.
    vpipe_d[0] = mem_en && !mem_we;
    for (int unsigned i = 1; i < MEM_LAT; i++) vpipe_d[i] = vpipe_q[i-1];
    if (restart) vpipe_d = '0;
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      pending_q <= '0;
      vpipe_q   <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      pending_q <= pending_d;
      vpipe_q   <= vpipe_d;
    end
  end

  // Registered RAM command, host grant and sticky restart flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      host_gnt    <= 1'b0;
      restart_err <= 1'b0;
    end else begin
      mem_en    <= do_read || do_host;
      mem_we    <= do_host;
      mem_addr  <= do_host ? host_addr : (do_read ? rd_addr_q : '0);
      mem_wdata <= do_host ? host_data : '0;
      host_gnt  <= do_host;
      if (restart) restart_err <= 1'b1;
    end
  end

  // FIFO push side and status
  always_comb begin
    fifo_wreq  = vpipe_q[MEM_LAT-1];
    fifo_wdata = fifo_wreq ? mem_rdata : '0;
    busy       = (state_q != IDLE);
  end

endmodule

// File: tb/tb_fb_fetch_arbiter.sv
// tb_fb_fetch_arbiter: randomized host/FIFO-drain traffic against a
// queue-based reference model; a negedge monitor pops expected outputs.
module tb_fb_fetch_arbiter;

  localparam int H    = 16;
  localparam int V    = 8;
  localparam int NPIX = H * V;
  localparam int AW   = 19;
  localparam int DW   = 24;
  localparam int FD   = 16;
  localparam int LW   = 8;
  localparam int ML   = 2;
  localparam int CW   = $clog2(FD + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          host_req = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_data = '0;
  logic          host_gnt, mem_en, mem_we, fifo_wreq, busy, restart_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, fifo_wdata;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  fb_fetch_arbiter #(
    .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DATA_W(DW),
    .FIFO_DEPTH(FD), .LOW_WATER(LW), .MEM_LAT(ML)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .host_req(host_req), .host_addr(host_addr), .host_data(host_data),
    .host_gnt(host_gnt), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fifo_count(fifo_count), .fifo_wreq(fifo_wreq), .fifo_wdata(fifo_wdata),
    .busy(busy), .restart_err(restart_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pix_init(input int a);
    return DW'(a * 40503 + 17);
  endfunction

  function automatic logic [63:0] bus_pack(input logic en, input logic we,
                                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {19'b0, en, en & we, en ? a : {AW{1'b0}}, (en && we) ? d : {DW{1'b0}}};
  endfunction

  // ---------------- environment: frame RAM and pixel FIFO ----------------
  bit            ram_w [256];
  logic [DW-1:0] ram_d [256];
  logic [DW-1:0] rd_pipe [ML];
  bit            pop = 1'b0;
  int            p_host = 100;
  int            p_drain = 0;

  function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
    if (int'(a) < 256 && ram_w[a[7:0]]) return ram_d[a[7:0]];
    return pix_init(int'(a));
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we && int'(mem_addr) < 256) begin
      ram_w[mem_addr[7:0]] <= 1'b1;
      ram_d[mem_addr[7:0]] <= mem_wdata;
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? ram_rd(mem_addr) : '0;
    for (int i = 1; i < ML; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[ML-1];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fifo_count <= '0;
    else        fifo_count <= fifo_count + CW'(fifo_wreq) - CW'(pop && fifo_count != '0);
  end

  // Host requester: holds until granted, may move on the cycle after the grant
  initial begin
    forever begin
      @(negedge clk); #1;
      if ((host_req && host_gnt) || !host_req) begin
        if ($urandom_range(0, 99) < p_host) begin
          host_req  = 1'b1;
          host_addr = AW'($urandom_range(0, 200));
          host_data = DW'($urandom);
        end else begin
          host_req = 1'b0;
        end
      end
      pop = (fifo_count != '0) && ($urandom_range(0, 99) < p_drain);
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct packed {
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          gnt;
    logic          wreq;
    logic [DW-1:0] fd;
    logic          busy;
    logic          err;
  } exp_t;

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } infl_t;

  exp_t          exp_q[$];
  infl_t         infl[$];
  logic [DW-1:0] mshadow [256];

  // Model: every rising edge predicts what the DUT shows during the next cycle.
  initial begin
    exp_t          e;
    bit            m_fetch, m_drain, m_err, wr_pend, restart, elig, urg, rd, wr;
    int            m_next, pend, lvl, cyc;
    logic [7:0]    wr_a;
    logic [DW-1:0] wr_d;
    m_fetch = 0; m_drain = 0; m_err = 0; wr_pend = 0; m_next = 0; cyc = 0;
    wr_a = '0; wr_d = '0;
    for (int i = 0; i < 256; i++) mshadow[i] = pix_init(i);
    forever begin
      @(posedge clk);
      e = '0;
      if (!rst_n) begin
        m_fetch = 0; m_drain = 0; m_err = 0; m_next = 0; wr_pend = 0;
        infl.delete();
      end else begin
        if (wr_pend) mshadow[wr_a] = wr_d;
        wr_pend = 0;
        pend    = infl.size();
        lvl     = int'(fifo_count) + pend;
        restart = frame_start && (m_fetch || m_drain);
        elig    = m_fetch && !frame_start && (lvl < FD);
        urg     = elig && (lvl < LW);
        rd      = urg || (elig && !host_req);
        wr      = host_req && !urg;
        if (rd) begin
          e.en = 1; e.addr = AW'(m_next);
        end
        if (wr) begin
          e.en = 1; e.we = 1; e.addr = host_addr; e.wd = host_data; e.gnt = 1;
          wr_pend = 1; wr_a = host_addr[7:0]; wr_d = host_data;
        end
        if (restart) infl.delete();
        else while (infl.size() > 0 && infl[0].due <= cyc) void'(infl.pop_front());
        if (rd) infl.push_back('{due: cyc + 1 + ML, d: mshadow[m_next]});
        if (frame_start) begin
          m_err   = m_err | restart;
          m_fetch = 1; m_drain = 0; m_next = 0;
        end else if (rd) begin
          if (m_next == NPIX - 1) begin
            m_fetch = 0; m_drain = 1;
          end else begin
            m_next++;
          end
        end else if (m_drain && pend == 0) begin
          m_drain = 0;
        end
        e.wreq = (infl.size() > 0) && (infl[0].due == cyc + 1);
        e.fd   = e.wreq ? infl[0].d : '0;
        e.busy = m_fetch || m_drain;
        e.err  = m_err;
      end
      exp_q.push_back(e);
      cyc++;
    end
  end

  int rd_cnt = 0;
  int last_rd = -1;
  int first_rd = -1;
  bit got_first = 0;

  // Monitor: compares DUT outputs mid-cycle against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mem_bus", bus_pack(mem_en, mem_we, mem_addr, mem_wdata),
            bus_pack(e.en, e.we, e.addr, e.wd));
        chk("host_gnt", 64'(host_gnt), 64'(e.gnt));
        chk("fifo_push", {39'b0, fifo_wreq, fifo_wreq ? fifo_wdata : {DW{1'b0}}},
            {39'b0, e.wreq, e.wreq ? e.fd : {DW{1'b0}}});
        chk("status", 64'({busy, restart_err}), 64'({e.busy, e.err}));
      end
      if (mem_en && !mem_we) begin
        rd_cnt++;
        last_rd = int'(mem_addr);
        if (!got_first) begin
          first_rd  = int'(mem_addr);
          got_first = 1;
        end
      end
    end
  end

  task automatic arm();
    rd_cnt = 0; last_rd = -1; first_rd = -1; got_first = 0;
  endtask

  task automatic pulse_frame();
    @(negedge clk); #1 frame_start = 1'b1;
    @(negedge clk); #1 frame_start = 1'b0;
    arm();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    #1 chk(name, 64'(busy), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_en"}, 64'(mem_en), 64'(0));
    chk({tag, "_mem_we"}, 64'(mem_we), 64'(0));
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
    chk({tag, "_host_gnt"}, 64'(host_gnt), 64'(0));
    chk({tag, "_fifo_wreq"}, 64'(fifo_wreq), 64'(0));
    chk({tag, "_fifo_wdata"}, 64'(fifo_wdata), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_restart_err"}, 64'(restart_err), 64'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    // T1: reset held with a host request pending
    p_host = 100; p_drain = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("t1_req_held", 64'(host_req), 64'(1));
    check_all_zero("t1_rst");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // T2: fill with no draining and no host traffic
    p_host = 0;
    repeat (4) @(negedge clk);
    pulse_frame();
    repeat (40) @(negedge clk);
    #1;
    chk("t2_reads_capped", 64'(rd_cnt), 64'(FD));
    chk("t2_fifo_full", 64'(fifo_count), 64'(FD));
    chk("t2_first_addr", 64'(first_rd), 64'(0));
    chk("t2_busy", 64'(busy), 64'(1));

    // T3/T4: mixed host traffic and draining through end of frame
    p_host = 70; p_drain = 50;
    wait_idle("t4_frame_done", 4000);
    chk("t4_last_addr", 64'(last_rd), 64'(NPIX - 1));
    chk("t4_read_total", 64'(rd_cnt), 64'(NPIX));
    p_host = 80;
    repeat (30) @(negedge clk);
    #1 chk("t4_no_extra_reads", 64'(rd_cnt), 64'(NPIX));

    // T5: restart mid-frame with reads in flight
    p_host = 40; p_drain = 60;
    pulse_frame();
    k = 0;
    while (last_rd < 60 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("t5_reached_mid_frame", 64'(last_rd >= 60), 64'(1));
    pulse_frame();
    repeat (20) @(negedge clk);
    #1;
    chk("t5_restart_addr0", 64'(first_rd), 64'(0));
    chk("t5_restart_err", 64'(restart_err), 64'(1));
    wait_idle("t5_frame_done", 4000);
    chk("t5_err_sticky", 64'(restart_err), 64'(1));
    chk("t5_last_addr", 64'(last_rd), 64'(NPIX - 1));

    // T6: asynchronous reset in the middle of a fetch
    pulse_frame();
    repeat (30) @(negedge clk);
    #1;
    chk("t6_pre_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1 check_all_zero("t6_async");
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    pulse_frame();
    repeat (10) @(negedge clk);
    #1;
    chk("t6_addr0", 64'(first_rd), 64'(0));
    chk("t6_err_clear", 64'(restart_err), 64'(0));
    wait_idle("t6_frame_done", 4000);
    chk("t6_read_total", 64'(rd_cnt), 64'(NPIX));
    chk("t6_err_still_clear", 64'(restart_err), 64'(0));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
